jtag_tap_param: RTL and testbench
=================================

Name: jtag_tap_param

Overview:
- Parametrised JTAG TAP port, oversampled in the system clock domain. Successor to the fixed-width JTAG port.
- Synchronises raw tck/tms/tdi pins and runs the full 16-state IEEE 1149.1 TAP FSM.
- Holds an IR_WIDTH instruction register and selects BYPASS, IDCODE or a DR_WIDTH user data register.
- Exposes the captured instruction, the user data and an update pulse to the core, plus debug state for hex display.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
DR_WIDTH, 16, user data register and IDCODE width (>=2)
IDCODE_INSTR, 4'h1, instruction selecting the IDCODE register (IR_WIDTH bits)
ID_VALUE, 16'h5249, value captured into IDCODE (DR_WIDTH bits)
SYNC_STAGES, 2, synchroniser flops per pin (>=2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
tck  in  1  raw JTAG clock pin (asynchronous)
tms  in  1  raw JTAG mode select pin
tdi  in  1  raw JTAG data in pin
tdo  out 1  JTAG data out, registered
wr_data  in  DR_WIDTH  value loaded into the user DR at Capture-DR
do_update  out 1  one-clk pulse on entry to Update-DR while the user DR is selected
instr_line  out IR_WIDTH  current instruction (updated at Update-IR)
data_line  out DR_WIDTH  user DR contents latched at Update-DR
dbg_state  out 4  current TAP state encoding
dbg_shift  out DR_WIDTH  live selected shift register (IR zero-extended)

Behaviour:
- Synchronisation and edges:
  - tck, tms and tdi each pass through SYNC_STAGES flops.
  - tck_rise and tck_fall are single-clk pulses from the last two tck sync flops.
  - Legal tck high and low phases are each at least SYNC_STAGES+2 clk periods. Shorter pulses are unsupported.
- TAP FSM:
  - Standard 16 states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
  - Advances only on the tck_rise pulse, using synced tms. Transitions follow the standard table.
  - Five consecutive tck_rise with tms=1 reach TLR from any state.
- Instruction register:
  - IR_WIDTH shift register, LSB out.
  - CapIR loads the constant {IR_WIDTH-2 zeros, 2'b01}.
  - ShIR (on tck_rise) shifts tdi in at the MSB.
  - On tck_rise leaving UpdIR's predecessor (i.e. when entering UpdIR), instr_line <= IR shift value.
  - In TLR, instr_line is forced to IDCODE_INSTR.
- Data register select (decoded from instr_line):
  - all ones selects BYPASS (1 bit, captures 0);
  - IDCODE_INSTR selects IDCODE (captures ID_VALUE);
  - any other value selects USER (captures wr_data).
- Shift behaviour:
  - Capture happens on the tck_rise that enters CapDR.
  - Shift happens on the tck_rise while in ShDR: tdi enters the MSB, the LSB goes out.
  - PauseDR/PauseIR hold the shift contents.
- Update:
  - On entry to UpdDR with USER selected: data_line <= user shift register, and do_update pulses for exactly 1 clk in the same cycle.
  - BYPASS and IDCODE updates have no effect.
- tdo:
  - Registered on tck_fall: LSB of the active shift register in ShDR/ShIR, otherwise 0.
  - Held between falls.
- Latency: raw tck edge to state/register change is SYNC_STAGES+1 clk.
- Reset (synchronous, rst=1), all at the next clk edge:
  - state=TLR, IR shift=0, instr_line=IDCODE_INSTR;
  - all DR shift registers cleared, data_line=0;
  - tdo=0, do_update=0, sync flops=0.
- Reset mid-shift: contents are discarded; data_line is not updated and no do_update pulse occurs.
- Simultaneous events:
  - rst has priority over any tck edge in the same cycle.
  - tck_rise and tck_fall cannot coincide.
- Widths: no arithmetic. IR values are zero-extended on dbg_shift.

Decomposition:
- Shared package jtag_pkg:
  - tap_state_t enum with 4-bit codes matching the standard (TLR=4'hF, RTI=4'hC, ... UpdIR=4'hD);
  - function next_tap_state(state, tms);
  - localparam for the CapIR constant.
- Sub-module jtag_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs, instantiated for tck. tms and tdi use its synced output only.

Test Plan:
- Reset: hold rst 2 clk -> dbg_state=4'hF, instr_line=4'h1, data_line=0, tdo=0, do_update=0.
- TLR recovery: walk the FSM to ShDR, then 5 tck with tms=1 -> dbg_state=TLR, instr_line=4'h1 regardless of the previous IR.
- IDCODE scan: after reset, go TLR->RTI->SelDR->CapDR->ShDR and shift 16 bits of tdi=0 -> tdo sequence LSB-first is 16'h5249, and no do_update pulse.
- IR then user DR: shift IR=4'h3 (tdo emits 1,0,0,0 from CapIR), then UpdIR -> instr_line=4'h3. With wr_data=16'hBEEF, do a DR scan shifting in 16'h1234 -> tdo emits 16'hBEEF LSB-first, data_line=16'h1234, and do_update is high exactly 1 clk.
- Bypass: IR=4'hF, DR scan of 8 bits 8'b1011_0010 -> tdo emits a 0 then the input delayed by one bit, and data_line is unchanged.
- Reset mid-shift: assert rst during ShDR after 5 of 16 bits with USER selected -> TLR, data_line=0, and no do_update pulse.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: standard 4-bit state codes, the next-state table
// and the data-register selection type.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_t;

  // Low bits loaded at Capture-IR; the rest of the IR is zero-filled.
  localparam logic [1:0] CAPIR_LSBS = 2'b01;

  function automatic tap_state_t next_tap_state(input tap_state_t state, input logic tms);
    tap_state_t nxt;
    case (state)
      TAP_TLR:     nxt = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:     nxt = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR:   nxt = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR:   nxt = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:    nxt = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR:   nxt = tms ? TAP_UPDDR : TAP_PAUSEDR;
      TAP_PAUSEDR: nxt = tms ? TAP_EX2DR : TAP_PAUSEDR;
      TAP_EX2DR:   nxt = tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR:   nxt = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR:   nxt = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR:   nxt = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:    nxt = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR:   nxt = tms ? TAP_UPDIR : TAP_PAUSEIR;
      TAP_PAUSEIR: nxt = tms ? TAP_EX2IR : TAP_PAUSEIR;
      TAP_EX2IR:   nxt = tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR:   nxt = tms ? TAP_SELDR : TAP_RTI;
      default:     nxt = TAP_TLR;
    endcase
    return nxt;
  endfunction

  function automatic logic is_ir_state(input tap_state_t state);
    return (state == TAP_SELIR) || (state == TAP_CAPIR) || (state == TAP_SHIR) ||
           (state == TAP_EX1IR) || (state == TAP_PAUSEIR) || (state == TAP_EX2IR) ||
           (state == TAP_UPDIR);
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Multi-flop synchroniser for an edge pin plus companion data pins, with
// single-clk rise/fall pulses derived from the synchronised edge pin.
module jtag_sync_edge #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             edge_pin,
  input  logic [WIDTH-1:0] data_pins,
  output logic [WIDTH-1:0] data_sync,
  output logic             rise,
  output logic             fall
);

  logic [WIDTH:0] stage_q [STAGES];
  logic [WIDTH:0] stage_d [STAGES];
  logic           hist_q;
  logic           hist_d;

  assign stage_d[0] = {data_pins, edge_pin};

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      assign stage_d[gi] = stage_q[gi-1];
    end
  endgenerate

  assign hist_d = stage_q[STAGES-1][0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      hist_q <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
      hist_q <= hist_d;
    end
  end

  // Data pins leave the chain at the same depth as the edge pin, so a
  // pulse sees the tms/tdi values that were present at the raw edge.
  assign data_sync = stage_q[STAGES-1][WIDTH:1];
  assign rise      = stage_q[STAGES-1][0] & ~hist_q;
  assign fall      = ~stage_q[STAGES-1][0] & hist_q;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP oversampled in the clk domain: 16-state FSM,
// instruction register and BYPASS / IDCODE / user data registers.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = 4,
  parameter int                  DR_WIDTH     = 16,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'h1,
  parameter logic [DR_WIDTH-1:0] ID_VALUE     = 16'h5249,
  parameter int                  SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  input  logic [DR_WIDTH-1:0] wr_data,
  output logic                do_update,
  output logic [IR_WIDTH-1:0] instr_line,
  output logic [DR_WIDTH-1:0] data_line,
  output logic [3:0]          dbg_state,
  output logic [DR_WIDTH-1:0] dbg_shift
);

  localparam logic [IR_WIDTH-1:0] CAPIR_VALUE = IR_WIDTH'(CAPIR_LSBS);
  localparam logic [IR_WIDTH-1:0] BYPASS_INSTR = '1;

  logic [1:0] pins_sync;
  logic       tck_rise;
  logic       tck_fall;
  logic       tms_s;
  logic       tdi_s;

  jtag_sync_edge #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .edge_pin  (tck),
    .data_pins ({tdi, tms}),
    .data_sync (pins_sync),
    .rise      (tck_rise),
    .fall      (tck_fall)
  );

  assign tms_s = pins_sync[0];
  assign tdi_s = pins_sync[1];

  tap_state_t          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                bp_q, bp_d;
  logic [DR_WIDTH-1:0] id_q, id_d;
  logic [DR_WIDTH-1:0] user_q, user_d;
  logic [DR_WIDTH-1:0] data_q, data_d;
  logic                upd_q, upd_d;
  logic                tdo_q, tdo_d;
  dr_sel_t             dr_sel;

  // BYPASS wins if IDCODE_INSTR is ever configured as all ones.
  always_comb begin
    if (instr_q == BYPASS_INSTR)      dr_sel = SEL_BYPASS;
    else if (instr_q == IDCODE_INSTR) dr_sel = SEL_IDCODE;
    else                              dr_sel = SEL_USER;
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    instr_d = instr_q;
    bp_d    = bp_q;
    id_d    = id_q;
    user_d  = user_q;
    data_d  = data_q;
    upd_d   = 1'b0;
    tdo_d   = tdo_q;

    if (tck_rise) begin
      state_d = next_tap_state(state_q, tms_s);

      if (state_q == TAP_SHIR)  ir_d    = {tdi_s, ir_q[IR_WIDTH-1:1]};
      if (state_d == TAP_CAPIR) ir_d    = CAPIR_VALUE;
      if (state_d == TAP_UPDIR) instr_d = ir_q;

      if (state_q == TAP_SHDR) begin
        case (dr_sel)
          SEL_BYPASS: bp_d   = tdi_s;
          SEL_IDCODE: id_d   = {tdi_s, id_q[DR_WIDTH-1:1]};
          default:    user_d = {tdi_s, user_q[DR_WIDTH-1:1]};
        endcase
      end

      if (state_d == TAP_CAPDR) begin
        case (dr_sel)
          SEL_BYPASS: bp_d   = 1'b0;
          SEL_IDCODE: id_d   = ID_VALUE;
          default:    user_d = wr_data;
        endcase
      end

      if (state_d == TAP_UPDDR && dr_sel == SEL_USER) begin
        data_d = user_q;
        upd_d  = 1'b1;
      end
    end

    if (tck_fall) begin
      case (state_q)
        TAP_SHIR: tdo_d = ir_q[0];
        TAP_SHDR: begin
          case (dr_sel)
            SEL_BYPASS: tdo_d = bp_q;
            SEL_IDCODE: tdo_d = id_q[0];
            default:    tdo_d = user_q[0];
          endcase
        end
        default:  tdo_d = 1'b0;
      endcase
    end

    if (state_q == TAP_TLR) instr_d = IDCODE_INSTR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TAP_TLR;
      ir_q    <= '0;
      instr_q <= IDCODE_INSTR;
      bp_q    <= 1'b0;
      id_q    <= '0;
      user_q  <= '0;
      data_q  <= '0;
      upd_q   <= 1'b0;
      tdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      instr_q <= instr_d;
      bp_q    <= bp_d;
      id_q    <= id_d;
      user_q  <= user_d;
      data_q  <= data_d;
      upd_q   <= upd_d;
      tdo_q   <= tdo_d;
    end
  end

  // Debug view follows whichever register a scan would currently shift.
  always_comb begin
    dbg_shift = '0;
    if (is_ir_state(state_q)) begin
      dbg_shift = DR_WIDTH'(ir_q);
    end else begin
      case (dr_sel)
        SEL_BYPASS: dbg_shift[0] = bp_q;
        SEL_IDCODE: dbg_shift    = id_q;
        default:    dbg_shift    = user_q;
      endcase
    end
  end

  assign tdo        = tdo_q;
  assign do_update  = upd_q;
  assign instr_line = instr_q;
  assign data_line  = data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Scoreboard bench for jtag_tap_param: the driver queues expected tdo bits
// and update values, a monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_jtag_tap_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        tck, tms, tdi;
  logic        tdo;
  logic [15:0] wr_data;
  logic        do_update;
  logic [3:0]  instr_line;
  logic [15:0] data_line;
  logic [3:0]  dbg_state;
  logic [15:0] dbg_shift;

  always #5 clk = ~clk;

  jtag_tap_param #(
    .IR_WIDTH     (4),
    .DR_WIDTH     (16),
    .IDCODE_INSTR (4'h1),
    .ID_VALUE     (16'h5249),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tck        (tck),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .wr_data    (wr_data),
    .do_update  (do_update),
    .instr_line (instr_line),
    .data_line  (data_line),
    .dbg_state  (dbg_state),
    .dbg_shift  (dbg_shift)
  );

  int          checks   = 0;
  int          failures = 0;
  logic        exp_tdo_q[$];
  logic [15:0] exp_upd_q[$];
  logic        tdo_strobe = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full tck period; optionally queue the tdo value expected after the fall.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, input logic chk, input logic exp);
    tms = tms_v;
    tdi = tdi_v;
    wait_clk(2);
    tck = 1'b1;
    wait_clk(6);
    tck = 1'b0;
    wait_clk(6);
    if (chk) begin
      exp_tdo_q.push_back(exp);
      tdo_strobe = 1'b1;
      wait_clk(1);
      tdo_strobe = 1'b0;
    end
  endtask

  // Full scan from RTI back to RTI, n bits in LSB-first, checking tdo bits.
  task automatic scan(input logic is_ir, input int n, input logic [15:0] din, input logic [15:0] dout);
    logic e;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    if (is_ir) tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b1, dout[0]);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) e = 1'b0;
      else            e = dout[i+1];
      tck_cycle(i == n - 1, din[i], 1'b1, e);
    end
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic monitor();
    logic        e;
    logic [15:0] u;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tdo_strobe) begin
          if (exp_tdo_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tdo_sample: got %b with no expected bit queued", tdo);
          end else begin
            e = exp_tdo_q.pop_front();
            check("tdo", {15'd0, tdo}, {15'd0, e});
          end
        end
        if (do_update) begin
          if (exp_upd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL do_update: unexpected pulse, data_line %h, required no pulse", data_line);
          end else begin
            u = exp_upd_q.pop_front();
            check("update_data", data_line, u);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0; wr_data = 16'h0000;
    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset
    wait_clk(2);
    check("rst_state",     {12'd0, dbg_state}, 16'h000F);
    check("rst_instr",     {12'd0, instr_line}, 16'h0001);
    check("rst_data_line", data_line, 16'h0000);
    check("rst_tdo",       {15'd0, tdo}, 16'h0000);
    check("rst_do_update", {15'd0, do_update}, 16'h0000);
    check("rst_dbg_shift", dbg_shift, 16'h0000);
    rst = 1'b0;
    wait_clk(2);

    // IDCODE scan (no update expected)
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rti_state", {12'd0, dbg_state}, 16'h000C);
    scan(1'b0, 16, 16'h0000, 16'h5249);
    check("idcode_data_line", data_line, 16'h0000);

    // IR = 3, then user DR scan
    scan(1'b1, 4, 16'h0003, 16'h0001);
    check("ir3_instr", {12'd0, instr_line}, 16'h0003);
    wr_data = 16'hBEEF;
    exp_upd_q.push_back(16'h1234);
    scan(1'b0, 16, 16'h1234, 16'hBEEF);
    check("user_data_line", data_line, 16'h1234);

    // Bypass
    scan(1'b1, 4, 16'h000F, 16'h0001);
    check("bypass_instr", {12'd0, instr_line}, 16'h000F);
    scan(1'b0, 8, 16'h00B2, 16'h0064);
    check("bypass_data_line", data_line, 16'h1234);

    // TLR recovery from ShDR
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("walk_shdr_state", {12'd0, dbg_state}, 16'h0002);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("tlr_state", {12'd0, dbg_state}, 16'h000F);
    check("tlr_instr", {12'd0, instr_line}, 16'h0001);

    // Reset mid-shift with USER selected
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    scan(1'b1, 4, 16'h0003, 16'h0001);
    check("ir3b_instr", {12'd0, instr_line}, 16'h0003);
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tck_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("midshift_state", {12'd0, dbg_state}, 16'h0002);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    check("midrst_state",     {12'd0, dbg_state}, 16'h000F);
    check("midrst_data_line", data_line, 16'h0000);
    check("midrst_instr",     {12'd0, instr_line}, 16'h0001);
    check("midrst_tdo",       {15'd0, tdo}, 16'h0000);
    wait_clk(20);

    check("tdo_queue_drained",    16'(exp_tdo_q.size()), 16'h0000);
    check("update_queue_drained", 16'(exp_upd_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
